load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_load_align.sv | 33 +++
 rtl/load_store_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions.
// RISC-V width codes, FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  // funct3[1:0] is the access size: 00 byte, 01 half, 10 word
  function automatic logic is_aligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    return (sz == 2'b00)
        || (sz == 2'b01 && !off[0])
        || (sz == 2'b10 && off == 2'b00);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-oriented data memory bus.
// The LSU is the master; the memory (or bench) is the slave.
interface lsu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [3:0]               mem_be;
  logic                     mem_gnt;
  logic                     mem_rvalid;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts and extends the addressed byte/half of a read word.
// Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16]
                           : rdata_i[15:0];
    data_o   = rdata_i;
    unique case (1'b1)
      funct3_i == LB:
        data_o = {{24{byte_sel[7]}}, byte_sel};
      funct3_i == LBU:
        data_o = {24'b0, byte_sel};
      funct3_i == LH:
        data_o = {{16{half_sel[15]}}, half_sel};
      funct3_i == LHU:
        data_o = {16'b0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one outstanding access,
// stalls the pipeline until the memory completes it.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read_m,
  input  logic                     mem_write_m,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    store_data,
  output logic                     lsu_stall,
  output logic [DATA_WIDTH-1:0]    load_data,
  output logic                     misaligned,
  lsu_if.master                    mem
);

  lsu_state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [2:0]               funct3_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [3:0]               be_q, be_d;
  logic [DATA_WIDTH-1:0]    load_data_q;
  logic [DATA_WIDTH-1:0]    aligned_data;

  logic op_valid, op_legal, op_aligned;
  logic idle_op, start;

  assign op_valid   = mem_read_m | mem_write_m;
  assign op_aligned = is_aligned(funct3[1:0], addr[1:0]);

  // a write wins when both strobes are set
  always_comb begin
    if (mem_write_m)
      op_legal = funct3 inside {SB, SH, SW};
    else
      op_legal = funct3 inside {LB, LH, LW, LBU, LHU};
  end

  assign idle_op = (state_q == IDLE) && op_valid && op_legal;
  assign start   = idle_op && op_aligned;

  always_comb begin
    wdata_d = store_data;
    be_d    = 4'b1111;
    unique case (1'b1)
      funct3 == SB: begin
        wdata_d = {4{store_data[7:0]}};
        be_d    = 4'b0001 << addr[1:0];
      end
      funct3 == SH: begin
        wdata_d = {2{store_data[15:0]}};
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (mem.mem_gnt)
              state_d = we_q ? DONE : WAIT;
      WAIT: if (mem.mem_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_stall      = 1'b0;
    misaligned     = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_be     = 4'b0000;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          lsu_stall  = start;
          misaligned = idle_op && !op_aligned;
        end
        REQ: begin
          lsu_stall   = 1'b1;
          mem.mem_req = 1'b1;
          mem.mem_we  = we_q;
          mem.mem_be  = be_q;
        end
        WAIT: lsu_stall = 1'b1;
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else if (start) begin
      addr_q   <= addr;
      funct3_q <= funct3;
      we_q     <= mem_write_m;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  lsu_load_align u_align (
    .funct3_i (funct3_q),
    .offset_i (addr_q[1:0]),
    .rdata_i  (mem.mem_rdata),
    .data_o   (aligned_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      load_data_q <= '0;
    else if (state_q == WAIT && mem.mem_rvalid)
      load_data_q <= aligned_data;
  end

  assign load_data     = load_data_q;
  assign mem.mem_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;

endmodule
